// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad matrix scanner.
package keypad_pkg;

  // Scanner FSM states.
  typedef enum logic [2:0] {
    SETTLE   = 3'd0,
    SCAN     = 3'd1,
    DEBOUNCE = 3'd2,
    EVENT    = 3'd3,
    HOLD     = 3'd4,
    RELDB    = 3'd5
  } state_t;

  // Index of the lowest set bit of vec (0 when vec is all zero).
  // Column vectors wider than 32 bits are not supported by this helper.
  function automatic logic [4:0] lsb_index(input logic [31:0] vec);
    logic [4:0] idx;
    logic       found;
    idx   = 5'd0;
    found = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (!found && vec[i]) begin
        idx   = 5'(i);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_next_state.sv
// Combinational next-state logic of the keypad scanner FSM.
module keypad_scanner_next_state
  import keypad_pkg::*;
(
  input  state_t state,
  input  logic   press,
  input  logic   snapshot_match,
  input  logic   counter_done,
  output state_t next_state
);

  // Transition table; scan_en override is applied by the parent.
  always_comb begin
    next_state = state;
    case (state)
      SETTLE: begin
        if (counter_done) next_state = SCAN;
        else              next_state = SETTLE;
      end
      SCAN: begin
        if (press) next_state = DEBOUNCE;
        else       next_state = SETTLE;
      end
      DEBOUNCE: begin
        if (!counter_done)       next_state = DEBOUNCE;
        else if (snapshot_match) next_state = EVENT;
        else                     next_state = SCAN;
      end
      EVENT: begin
        next_state = HOLD;
      end
      HOLD: begin
        if (press) next_state = HOLD;
        else       next_state = RELDB;
      end
      RELDB: begin
        if (press)             next_state = HOLD;
        else if (counter_done) next_state = SETTLE;
        else                   next_state = RELDB;
      end
      default: begin
        next_state = SETTLE;
      end
    endcase
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Keypad matrix scanner: one-hot row drive, 2-FF column synchroniser,
// press/release debounce and single-cycle key events.
// Optional auto-repeat enabled by defining KEYPAD_SCANNER_REPEAT_EN.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int NROWS        = 4,
  parameter int NCOLS        = 4,
  parameter int SETTLE_CYC   = 3,
  parameter int DEBOUNCE_CYC = 10,
  parameter int REPEAT_DELAY = 40,
  parameter int REPEAT_RATE  = 20
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     scan_en,
  input  logic [NCOLS-1:0]                         cols,
  output logic [NROWS-1:0]                         rows,
  output logic                                     key_valid,
  output logic [$clog2(NROWS)+$clog2(NCOLS)-1:0]   key_code,
  output logic                                     key_multi,
  output logic                                     key_held
);

  localparam int RW       = $clog2(NROWS);
  localparam int CW       = $clog2(NCOLS);
  localparam int MAX_BASE = (SETTLE_CYC > DEBOUNCE_CYC) ? SETTLE_CYC : DEBOUNCE_CYC;
  localparam int MAX_REP  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int MAX_T    = (MAX_BASE > MAX_REP) ? MAX_BASE : MAX_REP;
  localparam int CNT_W    = $clog2(MAX_T) + 1;

  state_t             state_r;
  state_t             fsm_next_s;
  state_t             next_state_s;
  logic [CNT_W-1:0]   counter_r;
  logic [RW-1:0]      row_idx_r;
  logic [RW-1:0]      row_idx_next_s;
  logic [NCOLS-1:0]   cols_meta_r;
  logic [NCOLS-1:0]   cols_s_r;
  logic [NCOLS-1:0]   snapshot_r;
  logic [NROWS-1:0]   rows_r;
  logic               key_valid_r;
  logic [RW+CW-1:0]   key_code_r;
  logic               key_multi_r;
  logic               key_held_r;
  logic               press_s;
  logic               snapshot_match_s;
  logic               counter_done_s;
  logic               row_advance_s;
  logic               rep_fire_s;
`ifdef KEYPAD_SCANNER_REPEAT_EN
  logic [CNT_W-1:0]   rep_target_r;
`endif

  // Two-stage synchroniser for the asynchronous column inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cols_meta_r <= {NCOLS{1'b0}};
      cols_s_r    <= {NCOLS{1'b0}};
    end else begin
      cols_meta_r <= cols;
      cols_s_r    <= cols_meta_r;
    end
  end

  // Status flags feeding the FSM.
  always_comb begin
    press_s          = |cols_s_r;
    snapshot_match_s = (cols_s_r == snapshot_r) && (snapshot_r != {NCOLS{1'b0}});
    counter_done_s   = 1'b0;
    case (state_r)
      SETTLE:          counter_done_s = (counter_r == CNT_W'(SETTLE_CYC - 1));
      DEBOUNCE, RELDB: counter_done_s = (counter_r == CNT_W'(DEBOUNCE_CYC - 1));
      default:         counter_done_s = 1'b0;
    endcase
  end

  keypad_scanner_next_state u_next_state (
    .state          (state_r),
    .press          (press_s),
    .snapshot_match (snapshot_match_s),
    .counter_done   (counter_done_s),
    .next_state     (fsm_next_s)
  );

  // scan_en override, row advance and auto-repeat trigger.
  always_comb begin
    if (scan_en) next_state_s = fsm_next_s;
    else         next_state_s = SETTLE;
    row_advance_s = scan_en && (((state_r == SCAN) && !press_s) ||
                                ((state_r == RELDB) && (fsm_next_s == SETTLE)));
    row_idx_next_s = row_idx_r;
    if (!row_advance_s)                      row_idx_next_s = row_idx_r;
    else if (row_idx_r == RW'(NROWS - 1))    row_idx_next_s = {RW{1'b0}};
    else                                     row_idx_next_s = row_idx_r + RW'(1);
`ifdef KEYPAD_SCANNER_REPEAT_EN
    rep_fire_s = scan_en && (state_r == HOLD) && press_s && (counter_r == rep_target_r);
`else
    rep_fire_s = 1'b0;
`endif
  end

  // FSM state register and shared counter (cleared on every state change).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= SETTLE;
      counter_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      if ((next_state_s != state_r) || !scan_en || rep_fire_s) begin
        counter_r <= {CNT_W{1'b0}};
      end else if (state_r == HOLD) begin
`ifdef KEYPAD_SCANNER_REPEAT_EN
        counter_r <= counter_r + CNT_W'(1);
`else
        counter_r <= {CNT_W{1'b0}};
`endif
      end else begin
        counter_r <= counter_r + CNT_W'(1);
      end
    end
  end

`ifdef KEYPAD_SCANNER_REPEAT_EN
  // Repeat interval: first repeat REPEAT_DELAY after the event (the event
  // cycle and the compare-to-pulse register stage account for the -2),
  // subsequent repeats and re-entry from RELDB use REPEAT_RATE.
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_target_r <= {CNT_W{1'b0}};
    end else if (next_state_s == EVENT) begin
      rep_target_r <= CNT_W'(REPEAT_DELAY - 2);
    end else if (rep_fire_s || ((state_r == RELDB) && (next_state_s == HOLD))) begin
      rep_target_r <= CNT_W'(REPEAT_RATE - 1);
    end else begin
      rep_target_r <= rep_target_r;
    end
  end
`endif

  // Row index, column snapshot and registered row drive.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_idx_r  <= {RW{1'b0}};
      snapshot_r <= {NCOLS{1'b0}};
      rows_r     <= {{(NROWS-1){1'b0}}, 1'b1};
    end else begin
      row_idx_r <= row_idx_next_s;
      if (scan_en && (state_r == SCAN) && press_s) snapshot_r <= cols_s_r;
      else                                         snapshot_r <= snapshot_r;
      if (scan_en) rows_r <= {{(NROWS-1){1'b0}}, 1'b1} << row_idx_next_s;
      else         rows_r <= {NROWS{1'b0}};
    end
  end

  // Key event outputs; key_held is also dropped when scanning is disabled
  // because the FSM abandons the held key.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_valid_r <= 1'b0;
      key_code_r  <= {(RW+CW){1'b0}};
      key_multi_r <= 1'b0;
      key_held_r  <= 1'b0;
    end else begin
      key_valid_r <= (next_state_s == EVENT) || rep_fire_s;
      if (next_state_s == EVENT) begin
        key_code_r  <= {row_idx_r, CW'(lsb_index(32'(snapshot_r)))};
        key_multi_r <= ($countones(snapshot_r) > 32'sd1);
      end else begin
        key_code_r  <= key_code_r;
        key_multi_r <= key_multi_r;
      end
      if (!scan_en)                                           key_held_r <= 1'b0;
      else if (next_state_s == EVENT)                         key_held_r <= 1'b1;
      else if ((state_r == RELDB) && (next_state_s == SETTLE)) key_held_r <= 1'b0;
      else                                                    key_held_r <= key_held_r;
    end
  end

  assign rows      = rows_r;
  assign key_valid = key_valid_r;
  assign key_code  = key_code_r;
  assign key_multi = key_multi_r;
  assign key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Self-checking bench for keypad_matrix_scanner (default geometry/timing).
// Repeat expectations follow KEYPAD_SCANNER_REPEAT_EN when it is defined.
module tb_keypad_matrix_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic       scan_en;
  logic [3:0] cols;
  logic [3:0] rows;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_multi;
  logic       key_held;

  // Keypad model: a key pattern appears on the columns while one of its rows is driven.
  logic       key_down;
  logic [3:0] key_rowmask;
  logic [3:0] key_cols;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef KEYPAD_SCANNER_REPEAT_EN
  localparam int EXP_REP95  = 3;
  localparam int EXP_REP200 = 9;
`else
  localparam int EXP_REP95  = 0;
  localparam int EXP_REP200 = 0;
`endif

  typedef struct {
    logic       scan_en;
    logic [3:0] rowmask;
    logic [3:0] kcols;
    logic [3:0] exp_rows;
    logic       exp_valid;
    logic       exp_held;
  } vec_t;

  vec_t idle_tbl[32];

  bit   ok;
  int   rep95, rep200, first_rep, lows, vcnt, changes, nz;
  logic [3:0] prev_rows;

  always #5 clk = ~clk;

  assign cols = (key_down && ((rows & key_rowmask) != 4'b0000)) ? key_cols : 4'b0000;

  keypad_matrix_scanner dut (
    .clk       (clk),
    .reset     (reset),
    .scan_en   (scan_en),
    .cols      (cols),
    .rows      (rows),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_multi (key_multi),
    .key_held  (key_held)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (key_valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Idle sweep table: 4-cycle dwell per row, no events, nothing held.
    for (int i = 0; i < 32; i++) begin
      idle_tbl[i] = '{1'b1, 4'b0000, 4'b0000, 4'b0001 << ((i / 4) % 4), 1'b0, 1'b0};
    end

    reset       = 1'b1;
    scan_en     = 1'b1;
    key_down    = 1'b0;
    key_rowmask = 4'b0000;
    key_cols    = 4'b0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rows", rows, 4'b0001);
    check("reset_valid", key_valid, 1'b0);
    check("reset_code", key_code, 4'b0000);
    check("reset_multi", key_multi, 1'b0);
    check("reset_held", key_held, 1'b0);
    reset = 1'b0;

    // Idle sweep, table driven; entry 0 is the cycle right after reset.
    for (int i = 0; i < 32; i++) begin
      if (i > 0) @(negedge clk);
      scan_en     = idle_tbl[i].scan_en;
      key_rowmask = idle_tbl[i].rowmask;
      key_cols    = idle_tbl[i].kcols;
      key_down    = (idle_tbl[i].kcols != 4'b0000);
      check($sformatf("idle_rows[%0d]", i), rows, idle_tbl[i].exp_rows);
      check($sformatf("idle_valid[%0d]", i), key_valid, idle_tbl[i].exp_valid);
      check($sformatf("idle_held[%0d]", i), key_held, idle_tbl[i].exp_held);
    end

    // Clean press on row 2, column 1.
    key_rowmask = 4'b0100;
    key_cols    = 4'b0010;
    key_down    = 1'b1;
    wait_valid(60, ok);
    check("press_event_seen", ok, 1'b1);
    check("press_code", key_code, 4'b1001);
    check("press_multi", key_multi, 1'b0);
    check("press_held", key_held, 1'b1);
    check("press_rows", rows, 4'b0100);
    rep95 = 0; rep200 = 0; first_rep = 0; lows = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (key_valid) begin
        if (i <= 95) rep95++;
        rep200++;
        if (first_rep == 0) first_rep = i;
        check("repeat_code", key_code, 4'b1001);
      end
      if (!key_held) lows++;
    end
    check("press_pulses_95", rep95, EXP_REP95);
    check("press_pulses_200", rep200, EXP_REP200);
    check("press_held_steady", lows, 0);
`ifdef KEYPAD_SCANNER_REPEAT_EN
    check("first_repeat_offset", first_rep, 40);
`endif

    // Release: 2 sync cycles + 1 HOLD cycle + 10 RELDB cycles.
    key_down = 1'b0;
    lows = 0; vcnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (!key_held) lows++;
      if (key_valid) vcnt++;
    end
    check("release_held_window", lows, 0);
    check("release_no_event", vcnt, 0);
    @(negedge clk);
    check("release_held_drop", key_held, 1'b0);
    check("release_row_advance", rows, 4'b1000);

    // Press bounce: column 1 on every row, 2 high / 2 low for 30 cycles.
    key_rowmask = 4'b1111;
    key_cols    = 4'b0010;
    vcnt = 0;
    for (int i = 0; i < 30; i++) begin
      key_down = (((i / 2) % 2) == 0);
      @(negedge clk);
      if (key_valid) vcnt++;
    end
    key_down  = 1'b0;
    changes   = 0;
    prev_rows = rows;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (key_valid) vcnt++;
      if (rows != prev_rows) changes++;
      prev_rows = rows;
    end
    check("bounce_no_event", vcnt, 0);
    check("bounce_scan_continues", changes >= 4, 1'b1);
    check("bounce_not_held", key_held, 1'b0);

    // Multi-key on row 1: columns 0 and 3.
    key_rowmask = 4'b0010;
    key_cols    = 4'b1001;
    key_down    = 1'b1;
    wait_valid(60, ok);
    check("multi_event_seen", ok, 1'b1);
    check("multi_code", key_code, 4'b0100);
    check("multi_flag", key_multi, 1'b1);

    // Release bounce: short release then re-press.
    lows = 0; vcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (key_valid) vcnt++;
    end
    key_down = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (!key_held) lows++;
      if (key_valid) vcnt++;
    end
    key_down = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (!key_held) lows++;
      if (key_valid) vcnt++;
    end
    check("relbounce_no_second_event", vcnt, 0);
    check("relbounce_held_stays", lows, 0);

    // Reset while in HOLD.
    reset = 1'b1;
    @(negedge clk);
    check("hold_reset_rows", rows, 4'b0001);
    check("hold_reset_held", key_held, 1'b0);
    check("hold_reset_valid", key_valid, 1'b0);
    check("hold_reset_code", key_code, 4'b0000);
    key_down = 1'b0;
    reset    = 1'b0;

    // scan_en: stop on row 2, rows go dark, resume on the same row.
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rows == 4'b0100) begin
        ok = 1'b1;
        break;
      end
    end
    check("scanen_reach_row2", ok, 1'b1);
    scan_en = 1'b0;
    @(negedge clk);
    check("scanen_rows_off", rows, 4'b0000);
    key_rowmask = 4'b1111;
    key_cols    = 4'b0001;
    key_down    = 1'b1;
    vcnt = 0; nz = 0;
    repeat (12) begin
      @(negedge clk);
      if (key_valid) vcnt++;
      if (rows != 4'b0000) nz++;
    end
    check("scanen_off_no_event", vcnt, 0);
    check("scanen_off_rows_stay", nz, 0);
    key_down = 1'b0;
    repeat (3) @(negedge clk);
    scan_en = 1'b1;
    @(negedge clk);
    check("scanen_resume_row", rows, 4'b0100);

    // Key on row 2, column 2 after resume.
    key_rowmask = 4'b0100;
    key_cols    = 4'b0100;
    key_down    = 1'b1;
    wait_valid(60, ok);
    check("resume_event_seen", ok, 1'b1);
    check("resume_code", key_code, 4'b1010);
    check("resume_multi", key_multi, 1'b0);
    key_down = 1'b0;
    repeat (20) @(negedge clk);
    check("resume_released", key_held, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
